hex_scan_ctrl: RTL and testbench
================================

Name: hex_scan_ctrl

Overview:
Parametrised multiplexed 7-segment driver with DIGITS hex digits and active-low anodes and segments. It is the next-generation dynamic_hex: scan length, digit count and dwell are set by parameters, and it adds PWM brightness, decimal points, leading-zero blanking and tear-free double-buffered loading. It sits between user logic and the board anode and segment pins.

Parameters:
DIGITS, 8, number of digits / anodes (2..16)
PWM_BITS, 3, slot length = 2**PWM_BITS ticks; brightness resolution
PRESCALE, 1562, clocks per tick (1 = advance every clock; benches use 1)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
data_i  in  4*DIGITS  nibble i = digit i; digit 0 is least significant (rightmost)
dp_i  in  DIGITS  decimal point request per digit, 1 = lit
load_i  in  1  one-cycle strobe capturing data_i/dp_i into the pending buffer
blank_lz_i  in  1  1 = blank leading zeros
bright_i  in  PWM_BITS  brightness; anode on for bright_i+1 of 2**PWM_BITS ticks per slot
an_o  out  DIGITS  active-low one-hot anode
ca_o..cg_o  out  1 each  active-low segments a..g
dp_o  out  1  active-low decimal point
frame_o  out  1  one-cycle pulse when a full scan completes and the active buffer updates
pending_o  out  1  1 = loaded data not yet displayed

Behaviour:
- Reset (rst_i=1 at an edge): an_o all 1, ca..cg=1, dp_o=1, frame_o=0, pending_o=0, prescaler/tick/digit counters=0, pending and active buffers=0.
- Prescaler counts 0..PRESCALE-1; a tick occurs in the cycle it equals PRESCALE-1, then it wraps to 0.
- On each tick, tick_cnt (PWM_BITS wide) increments. On wrap from all-1 to 0, digit_idx increments 0..DIGITS-1 and wraps to 0.
- Frame boundary: the cycle that is a tick with tick_cnt all-1 and digit_idx=DIGITS-1.
- Output stage is registered, with one cycle of latency from the counter state:
  - an_o[digit_idx] <= ~(tick_cnt <= bright_i && !blank); all other anodes <= 1.
  - Segments and dp_o are decoded from active nibble/dp for digit_idx in the same cycle.
  - With PRESCALE=1, the first edge after reset release drives an_o[0]=0.
- Segment decode, {ca..cg}:
  - 0:0000001  1:1001111  2:0010010  3:0000110  4:1001100  5:0100100  6:0100000  7:0001111
  - 8:0000000  9:0000100  A:0001000  b:1100000  C:0110001  d:1000010  E:0110000  F:0111000
- Leading-zero blanking: digit i (i>0) is blank when blank_lz_i=1 and active nibbles DIGITS-1..i are all 0.
  - Digit 0 is never blanked.
  - A blank digit keeps its anode at 1, even if its dp bit is set.
- Double buffering:
  - load_i copies data_i/dp_i to the pending buffer and sets pending_o on the next edge.
  - A later load_i before the boundary overwrites the pending buffer (last load wins).
  - At the frame boundary, if pending_o=1, active <= pending and pending_o <= 0.
  - load_i in the boundary cycle bypasses: active <= data_i/dp_i directly, and pending_o <= 0.
  - The active buffer never changes mid-frame.
- frame_o is registered: it is 1 for exactly the one cycle after every frame boundary, whether or not data updated.
- bright_i is sampled live, so changes take effect from the next cycle's comparison.
- Reset mid-frame: all state returns to its reset values on that edge, and any pending data is discarded.

Test Plan:
- DIGITS=4, PWM_BITS=2, PRESCALE=1, bright_i=3, reset → an_o cycles 1110,1101,1011,0111, 4 clocks each; frame_o pulses every 16 clocks.
- load_i with data_i=16'h12AF mid-frame → pending_o=1 and display unchanged until the boundary. Next frame: digit0 0111000(F), digit1 0001000(A), digit2 0010010(2), digit3 1001111(1). pending_o=0 with frame_o.
- bright_i=0 → each anode low for 1 of 4 clocks in its slot. bright_i=1 → low for 2 of 4 clocks.
- data_i=16'h0050, blank_lz_i=1 → an_o[3] stays 1; digits 1 and 0 show 5 and 0. With blank_lz_i=0 → digit3 shows 0000001. data_i=0 → only digit0 is lit.
- dp_i=4'b0100 → dp_o=0 only while an_o[2]=0.
- load_i exactly on the boundary cycle → active updates that boundary and pending_o stays 0. Separately, assert rst_i mid-frame after a load → an_o=1111 and pending_o=0; the pending data is never displayed.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// Multiplexed active-low 7-segment scanner with per-slot PWM brightness,
// decimal points, leading-zero blanking and a frame-synchronous double buffer.
module hex_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int PWM_BITS = 3,
  parameter int PRESCALE = 1562
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic [PWM_BITS-1:0]   bright_i,
  output logic [DIGITS-1:0]     an_o,
  output logic                  ca_o,
  output logic                  cb_o,
  output logic                  cc_o,
  output logic                  cd_o,
  output logic                  ce_o,
  output logic                  cf_o,
  output logic                  cg_o,
  output logic                  dp_o,
  output logic                  frame_o,
  output logic                  pending_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIG_MAX   = DW'(DIGITS - 1);

  logic [PW-1:0]        r_presc;
  logic [PWM_BITS-1:0]  r_tick;
  logic [DW-1:0]        r_digit;
  logic [4*DIGITS-1:0]  r_pend_data;
  logic [DIGITS-1:0]    r_pend_dp;
  logic [4*DIGITS-1:0]  r_act_data;
  logic [DIGITS-1:0]    r_act_dp;
  logic                 r_pending;
  logic                 r_frame;
  logic [DIGITS-1:0]    r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  logic                 w_tick;
  logic                 w_slot_end;
  logic                 w_boundary;
  logic [3:0]           w_nib;
  logic                 w_dp_bit;
  logic                 w_upper_zero;
  logic                 w_blank;
  logic                 w_lit;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b0000001;
      4'h1:    seg7 = 7'b1001111;
      4'h2:    seg7 = 7'b0010010;
      4'h3:    seg7 = 7'b0000110;
      4'h4:    seg7 = 7'b1001100;
      4'h5:    seg7 = 7'b0100100;
      4'h6:    seg7 = 7'b0100000;
      4'h7:    seg7 = 7'b0001111;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0000100;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b1100000;
      4'hC:    seg7 = 7'b0110001;
      4'hD:    seg7 = 7'b1000010;
      4'hE:    seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_slot_end = w_tick && (r_tick == '1);
  assign w_boundary = w_slot_end && (r_digit == DIG_MAX);

  // Select the current digit's nibble/dp and whether everything from it upward is zero.
  always_comb begin
    w_nib        = '0;
    w_dp_bit     = 1'b0;
    w_upper_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_digit == DW'(i)) begin
        w_nib        = r_act_data[4*i +: 4];
        w_dp_bit     = r_act_dp[i];
        w_upper_zero = ((r_act_data >> (4*i)) == '0);
      end
    end
  end

  assign w_blank = blank_lz_i && (r_digit != '0) && w_upper_zero;
  assign w_lit   = (r_tick <= bright_i) && !w_blank;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc     <= '0;
      r_tick      <= '0;
      r_digit     <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_pending   <= 1'b0;
      r_frame     <= 1'b0;
      r_an        <= '1;
      r_seg       <= '1;
      r_dp        <= 1'b1;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_tick  <= r_tick + PWM_BITS'(1);
        if (r_tick == '1)
          r_digit <= (r_digit == DIG_MAX) ? '0 : r_digit + DW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // A load landing on the boundary goes straight to the active buffer.
      if (load_i) begin
        r_pend_data <= data_i;
        r_pend_dp   <= dp_i;
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (load_i) begin
          r_act_data <= data_i;
          r_act_dp   <= dp_i;
        end else if (r_pending) begin
          r_act_data <= r_pend_data;
          r_act_dp   <= r_pend_dp;
        end
      end else if (load_i) begin
        r_pending <= 1'b1;
      end

      r_frame <= w_boundary;

      // Segments and dp are forced dark whenever the anode is off to avoid ghosting.
      r_an <= '1;
      if (w_lit)
        r_an[r_digit] <= 1'b0;
      r_seg <= w_lit ? seg7(w_nib) : 7'h7F;
      r_dp  <= ~(w_lit && w_dp_bit);
    end
  end

  assign an_o = r_an;
  assign {ca_o, cb_o, cc_o, cd_o, ce_o, cf_o, cg_o} = r_seg;
  assign dp_o      = r_dp;
  assign frame_o   = r_frame;
  assign pending_o = r_pending;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl (4 digits, 2 PWM bits, prescale 1) against a
// cycle-position reference model, with directed then randomized steps.
module tb_hex_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PWM_BITS = 2;
  localparam int PRESCALE = 1;
  localparam int SLOT     = 1 << PWM_BITS;
  localparam int FRAME    = SLOT * DIGITS;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [15:0]          data_i = '0;
  logic [3:0]           dp_i = '0;
  logic                 load_i = 1'b0;
  logic                 blank_lz_i = 1'b0;
  logic [1:0]           bright_i = 2'd3;
  logic [3:0]           an_o;
  logic                 ca_o, cb_o, cc_o, cd_o, ce_o, cf_o, cg_o;
  logic                 dp_o;
  logic                 frame_o;
  logic                 pending_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cyc;
  logic [15:0] m_act, m_pbuf;
  logic [3:0]  m_act_dp, m_pdp;
  bit          m_pend;
  logic [6:0]  seg_tab [16];

  hex_scan_ctrl #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .dp_i(dp_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i), .bright_i(bright_i), .an_o(an_o),
    .ca_o(ca_o), .cb_o(cb_o), .cc_o(cc_o), .cd_o(cd_o), .ce_o(ce_o), .cf_o(cf_o), .cg_o(cg_o),
    .dp_o(dp_o), .frame_o(frame_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: predict outputs from pre-edge model state, clock, update model, check.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_frame;
    int         p, d, tk;
    bit         blank, lit;
    logic [15:0] upper;
    if (rst_i) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    end else begin
      p     = cyc % FRAME;
      d     = p / SLOT;
      tk    = p % SLOT;
      upper = m_act >> (4*d);
      blank = blank_lz_i && (d > 0) && (upper == 16'h0);
      lit   = (tk <= int'(bright_i)) && !blank;
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg = lit ? seg_tab[upper[3:0]] : 7'h7F;
      e_dp  = lit ? ~m_act_dp[d] : 1'b1;
      e_frame = 1'b0;
    end
    @(posedge clk_i);
    if (rst_i) begin
      cyc = 0; m_act = '0; m_pbuf = '0; m_act_dp = '0; m_pdp = '0; m_pend = 0;
    end else begin
      if (cyc % FRAME == FRAME - 1) begin
        e_frame = 1'b1;
        if (load_i) begin
          m_act = data_i; m_act_dp = dp_i;
        end else if (m_pend) begin
          m_act = m_pbuf; m_act_dp = m_pdp;
        end
        m_pend = 0;
      end else if (load_i) begin
        m_pbuf = data_i; m_pdp = dp_i; m_pend = 1;
      end
      cyc++;
    end
    #1;
    chk("an_o", 32'(an_o), 32'(e_an));
    chk("seg", 32'({ca_o, cb_o, cc_o, cd_o, ce_o, cf_o, cg_o}), 32'(e_seg));
    chk("dp_o", 32'(dp_o), 32'(e_dp));
    chk("frame_o", 32'(frame_o), 32'(e_frame));
    chk("pending_o", 32'(pending_o), 32'(m_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] dp);
    data_i = d; dp_i = dp; load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    cyc = 0; m_act = '0; m_pbuf = '0; m_act_dp = '0; m_pdp = '0; m_pend = 0;

    // reset, then one idle frame scanning zeros at full brightness
    rst_i = 1'b1;
    run(2);
    rst_i = 1'b0;
    run(FRAME + 5);

    // mid-frame load stays pending until the boundary
    load_word(16'h12AF, 4'b0000);
    run(2 * FRAME);

    // reduced brightness
    bright_i = 2'd0;
    run(FRAME);
    bright_i = 2'd1;
    run(FRAME);
    bright_i = 2'd3;

    // leading-zero blanking
    blank_lz_i = 1'b1;
    load_word(16'h0050, 4'b0000);
    run(2 * FRAME);
    blank_lz_i = 1'b0;
    run(FRAME);
    blank_lz_i = 1'b1;
    load_word(16'h0000, 4'b1111);
    run(2 * FRAME);
    blank_lz_i = 1'b0;

    // decimal point on digit 2, with two back-to-back loads (last wins)
    load_word(16'h7777, 4'b1000);
    load_word(16'h1234, 4'b0100);
    run(2 * FRAME);

    // load on the boundary cycle bypasses the pending buffer
    while (cyc % FRAME != FRAME - 1) step();
    load_word(16'hABCD, 4'b0001);
    run(FRAME);

    // reset mid-frame after a load discards the pending data
    run(3);
    load_word(16'h9999, 4'b1111);
    run(2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    run(2 * FRAME);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      load_i = ($urandom_range(7) == 0);
      if (load_i) begin
        data_i = 16'($urandom);
        if ($urandom_range(3) == 0) data_i = data_i & 16'h00FF;
        if ($urandom_range(5) == 0) data_i = 16'h0;
        dp_i = 4'($urandom);
      end
      if ($urandom_range(15) == 0) blank_lz_i = 1'($urandom);
      if ($urandom_range(15) == 0) bright_i = 2'($urandom);
      rst_i = ($urandom_range(299) == 0);
      step();
    end
    load_i = 1'b0;
    rst_i = 1'b0;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
